// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiplier datapath: loader FSM states,
// their one-hot LED codes, the default frame header byte and the helper that
// sizes the element counter.
package matmul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_WRITE   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    localparam logic [3:0] LED_IDLE    = 4'b1000;
    localparam logic [3:0] LED_CAPTURE = 4'b0100;
    localparam logic [3:0] LED_WRITE   = 4'b0010;
    localparam logic [3:0] LED_DONE    = 4'b0001;

    localparam logic [7:0] HEADER_BYTE_DEFAULT = 8'hA5;

    // Counter must reach 2*ROWS*COLS inclusive (both operands fully written).
    function automatic int elem_count_w(input int rows, input int cols);
        return $clog2(2 * rows * cols + 1);
    endfunction

    function automatic logic [3:0] state_led(input state_t s);
        case (s)
            ST_IDLE:    return LED_IDLE;
            ST_CAPTURE: return LED_CAPTURE;
            ST_WRITE:   return LED_WRITE;
            default:    return LED_DONE;
        endcase
    endfunction

endpackage

// File: rtl/uart_rx_to_mem_rise_level_edge.sv
// rise_level_edge: two-flop synchroniser on a level input followed by a
// rising-edge detector. The pulse is one cycle wide and appears two cycles
// after the input rises; a held-high level produces a single pulse.
module rise_level_edge (
    input  logic clk,
    input  logic rst,
    input  logic level_in,
    output logic pulse
);

    // stage 0/1 form the synchroniser, stage 2 remembers the previous sample
    logic [2:0] stage_q;
    logic [2:0] stage_d;

    assign stage_d[0] = level_in;

    generate
        for (genvar gi = 1; gi < 3; gi++) begin : g_chain
            assign stage_d[gi] = stage_q[gi-1];
        end
    endgenerate

    // shift the level through the chain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign pulse = stage_q[1] & ~stage_q[2];

endmodule

// File: rtl/uart_rx_to_mem.sv
// uart_rx_to_mem: loads UART bytes row-major into operand memories A then B
// and raises load_done once B is full. Optional build macro RX_HEADER_EN:
// when defined, a load only starts after a HEADER_BYTE is seen in IDLE.
module uart_rx_to_mem
    import matmul_pkg::*;
#(
    parameter int ROWS   = 2,
    parameter int COLS   = 2,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
`ifdef RX_HEADER_EN
    ,
    parameter logic [DATA_W-1:0] HEADER_BYTE = DATA_W'(HEADER_BYTE_DEFAULT)
`endif
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                clear,
    input  logic                                rx_status,
    input  logic [DATA_W-1:0]                   rx_byte,
    output logic                                write_A,
    output logic                                write_B,
    output logic [ADDR_W-1:0]                   write_address,
    output logic [DATA_W-1:0]                   write_value,
    output logic                                load_done,
    output logic                                extra_byte,
    output logic [elem_count_w(ROWS,COLS)-1:0]  elem_count,
    output logic [3:0]                          state_LED
);

    localparam int N     = ROWS * COLS;
    localparam int CNT_W = elem_count_w(ROWS, COLS);
    localparam logic [CNT_W-1:0] N_C  = CNT_W'(N);
    localparam logic [CNT_W-1:0] N2_C = CNT_W'(2 * N);

    logic byte_pulse;

    rise_level_edge u_edge (
        .clk      (clk),
        .rst      (rst),
        .level_in (rx_status),
        .pulse    (byte_pulse)
    );

    state_t              state_q, state_d;
    logic [3:0]          led_q, led_d;
    logic                write_a_q, write_a_d;
    logic                write_b_q, write_b_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   value_q, value_d;
    logic                load_done_q, load_done_d;
    logic                extra_q, extra_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                take_byte;

    // next-state logic; strobes/address are prepared one cycle early so they
    // are registered and coincide exactly with the WRITE state
    always_comb begin
        state_d     = state_q;
        write_a_d   = 1'b0;
        write_b_d   = 1'b0;
        addr_d      = addr_q;
        value_d     = value_q;
        load_done_d = load_done_q;
        extra_d     = extra_q;
        count_d     = count_q;
        take_byte   = 1'b0;

        if (clear) begin
            // a pulse coinciding with clear is intentionally dropped
            state_d     = ST_IDLE;
            count_d     = '0;
            load_done_d = 1'b0;
            extra_d     = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (byte_pulse) begin
`ifdef RX_HEADER_EN
                        if (rx_byte == HEADER_BYTE) begin
                            state_d = ST_CAPTURE;
                        end
`else
                        take_byte = 1'b1;
`endif
                    end
                end
                ST_CAPTURE: begin
                    take_byte = byte_pulse;
                end
                ST_WRITE: begin
                    count_d = count_q + 1'b1;
                    if (count_d == N2_C) begin
                        state_d     = ST_DONE;
                        load_done_d = 1'b1;
                    end else begin
                        state_d = ST_CAPTURE;
                    end
                end
                ST_DONE: begin
                    if (byte_pulse) begin
                        extra_d = 1'b1;
                    end
                end
            endcase

            if (take_byte) begin
                state_d = ST_WRITE;
                value_d = rx_byte;
                if (count_q < N_C) begin
                    write_a_d = 1'b1;
                    addr_d    = ADDR_W'(count_q);
                end else begin
                    write_b_d = 1'b1;
                    addr_d    = ADDR_W'(count_q - N_C);
                end
            end
        end

        led_d = state_led(state_d);
    end

    // state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            led_q       <= LED_IDLE;
            write_a_q   <= 1'b0;
            write_b_q   <= 1'b0;
            addr_q      <= '0;
            value_q     <= '0;
            load_done_q <= 1'b0;
            extra_q     <= 1'b0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            led_q       <= led_d;
            write_a_q   <= write_a_d;
            write_b_q   <= write_b_d;
            addr_q      <= addr_d;
            value_q     <= value_d;
            load_done_q <= load_done_d;
            extra_q     <= extra_d;
            count_q     <= count_d;
        end
    end

    assign write_A       = write_a_q;
    assign write_B       = write_b_q;
    assign write_address = addr_q;
    assign write_value   = value_q;
    assign load_done     = load_done_q;
    assign extra_byte    = extra_q;
    assign elem_count    = count_q;
    assign state_LED     = led_q;

endmodule

// File: tb/tb_uart_rx_to_mem.sv
// Self-checking bench for uart_rx_to_mem: random bytes are pushed through a
// byte-level reference model and every write strobe is scoreboarded.
module tb_uart_rx_to_mem;

    localparam int ROWS   = 2;
    localparam int COLS   = 2;
    localparam int N      = ROWS * COLS;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 6;
    localparam int CW     = $clog2(2 * N + 1);
    localparam logic [7:0] HDR = 8'hA5;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clear = 1'b0;
    logic              rx_status = 1'b0;
    logic [DATA_W-1:0] rx_byte = '0;
    logic              write_A, write_B;
    logic [ADDR_W-1:0] write_address;
    logic [DATA_W-1:0] write_value;
    logic              load_done, extra_byte;
    logic [CW-1:0]     elem_count;
    logic [3:0]        state_LED;

    uart_rx_to_mem dut (
        .clk           (clk),
        .rst           (rst),
        .clear         (clear),
        .rx_status     (rx_status),
        .rx_byte       (rx_byte),
        .write_A       (write_A),
        .write_B       (write_B),
        .write_address (write_address),
        .write_value   (write_value),
        .load_done     (load_done),
        .extra_byte    (extra_byte),
        .elem_count    (elem_count),
        .state_LED     (state_LED)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model (byte level) ----------------
    int          m_n;
    bit          m_armed;
    bit          m_extra;
    logic [14:0] exp_q[$];
    logic [14:0] obs_q[$];

    function automatic void model_reset();
        m_n     = 0;
        m_armed = 0;
        m_extra = 0;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        logic [14:0] rec;
        if (!m_armed) begin
`ifdef RX_HEADER_EN
            if (b == HDR) m_armed = 1;
            return;
`else
            m_armed = 1;
`endif
        end
        if (m_n < 2 * N) begin
            rec = {(m_n >= N) ? 1'b1 : 1'b0, 6'(m_n % N), b};
            exp_q.push_back(rec);
            m_n++;
        end else begin
            m_extra = 1;
        end
    endfunction

    function automatic logic [3:0] exp_led();
        if (!m_armed)     return 4'b1000;
        if (m_n == 2 * N) return 4'b0001;
        return 4'b0100;
    endfunction

    // ---------------- write monitor ----------------
    always @(negedge clk) begin
        if (write_A || write_B) begin
            check("one_strobe", {31'd0, write_A & write_B}, 32'd0);
            check("done_during_write", {31'd0, load_done}, 32'd0);
            obs_q.push_back({write_B, write_address, write_value});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b, input int hold);
        @(negedge clk);
        rx_byte   = b;
        rx_status = 1'b1;
        repeat (hold) @(negedge clk);
        rx_status = 1'b0;
        repeat (2 + $urandom_range(0, 3)) @(negedge clk);
        $display("[TB] byte %02h hold %0d", b, hold);
        model_byte(b);
    endtask

    task automatic arm();
`ifdef RX_HEADER_EN
        send_byte(8'h11, 3);
        send_byte(HDR, 3);
`endif
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_reset();
    endtask

    task automatic verify(input string tag);
        int k;
        repeat (2) @(negedge clk);
        check({tag, ".n_writes"}, obs_q.size(), exp_q.size());
        k = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < k; i++) begin
            check({tag, ".write"}, obs_q[i], exp_q[i]);
        end
        obs_q.delete();
        exp_q.delete();
        check({tag, ".elem_count"}, elem_count, m_n);
        check({tag, ".load_done"}, {31'd0, load_done}, (m_n == 2 * N) ? 1 : 0);
        check({tag, ".extra_byte"}, {31'd0, extra_byte}, {31'd0, m_extra});
        check({tag, ".state_LED"}, state_LED, exp_led());
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".write_A"}, {31'd0, write_A}, 0);
        check({tag, ".write_B"}, {31'd0, write_B}, 0);
        check({tag, ".write_address"}, write_address, 0);
        check({tag, ".write_value"}, write_value, 0);
        check({tag, ".load_done"}, {31'd0, load_done}, 0);
        check({tag, ".extra_byte"}, {31'd0, extra_byte}, 0);
        check({tag, ".elem_count"}, elem_count, 0);
        check({tag, ".state_LED"}, state_LED, 4'b1000);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // full load with an incrementing pattern, then one stray byte
        arm();
        for (int i = 1; i <= 8; i++) send_byte(8'(i), 3);
        verify("load_1to8");
        send_byte(8'h33, 3);
        verify("extra_after_done");

        // zero/all-ones data into A only
        do_clear();
        verify("after_clear");
        arm();
        send_byte(8'h00, 3);
        send_byte(8'hFF, 4);
        send_byte(8'h00, 3);
        send_byte(8'hFF, 5);
        verify("zero_ff_a_only");

        // asynchronous reset in the middle of a load, then a full reload
        do_clear();
        arm();
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 3);
        verify("pre_reset");
        @(posedge clk);
        #3 rst = 1'b1;
        #1 check_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        arm();
        for (int i = 0; i < 8; i++) send_byte(8'($urandom), 3);
        verify("reload");

        // long held level gives one byte; pulse swallowed by clear
        do_clear();
        arm();
        send_byte(8'($urandom), 50);
        verify("held_high");
        @(negedge clk);
        rx_byte   = 8'h5C;
        rx_status = 1'b1;
        @(negedge clk);
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
        rx_status = 1'b0;
        repeat (3) @(negedge clk);
        verify("clear_with_pulse");

        // random loads of random length
        for (int r = 0; r < 8; r++) begin
            do_clear();
            if ($urandom_range(0, 1) == 1) send_byte(8'($urandom), 3);
            arm();
            for (int i = 0; i < int'($urandom_range(0, 10)); i++) begin
                send_byte(($urandom_range(0, 3) == 0) ? HDR : 8'($urandom),
                          3 + $urandom_range(0, 3));
            end
            verify("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
